axis_video_crop: RTL and testbench

//  AXI4-Stream video region-of-interest cropper, directly downstream of the video-in to AXI4-Stream bridge.

---
 rtl/axis_video_if.sv | 34 +++
 rtl/axis_video_crop.sv | 240 ++++++++++++++++++++++++
 tb/tb_axis_video_crop.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_video_if.sv
// ---------------------------------------------------------------------------
// axis_video_if
//   AXI4-Stream video bundle: one pixel per beat, tuser = start of frame,
//   tlast = end of line.
//   Signals: tdata, tvalid, tready, tuser, tlast.
//   Modports:
//     master - drives tdata/tvalid/tuser/tlast, samples tready
//     slave  - samples tdata/tvalid/tuser/tlast, drives tready
// ---------------------------------------------------------------------------
interface axis_video_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tuser;
    logic                  tlast;

    modport master (
        output tdata,
        output tvalid,
        output tuser,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tuser,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axis_video_crop.sv
// ---------------------------------------------------------------------------
// axis_video_crop
//   Region-of-interest cropper for an AXI4-Stream video stream. Tracks the
//   pixel/line position from tuser (SOF) and tlast (EOL) and forwards only
//   beats inside the window [crop_x, crop_x+crop_w) x [crop_y, crop_y+crop_h).
//   SOF/EOL are regenerated for the cropped frame. The output is registered
//   and backed by a 1-entry skid buffer, so it runs at full throughput under
//   arbitrary backpressure.
// Ports:
//   aclk, aresetn       clock, asynchronous active-low reset
//   crop_x/y/w/h        window config, sampled only on an accepted SOF beat
//   s_axis_video        slave stream  (input pixels)
//   m_axis_video        master stream (cropped pixels)
//   sof_early           pulse: SOF accepted while position was not (0,0)
//   eol_short           pulse: input line ended before the window right edge
//   frame_done          pulse: last beat of a cropped frame left the block,
//                       or a started cropped frame was cut short by a new SOF
// Handshake: a beat transfers on a rising edge where tvalid & tready are both
//   high. A master never drops tvalid, and never changes tdata/tuser/tlast,
//   while tvalid is high and tready is low. s_axis_video.tready never depends
//   combinationally on m_axis_video.tready (it is a register).
// ---------------------------------------------------------------------------
module axis_video_crop #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 12
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [CNT_WIDTH-1:0] crop_x,
    input  logic [CNT_WIDTH-1:0] crop_y,
    input  logic [CNT_WIDTH-1:0] crop_w,
    input  logic [CNT_WIDTH-1:0] crop_h,
    axis_video_if.slave          s_axis_video,
    axis_video_if.master         m_axis_video,
    output logic                 sof_early,
    output logic                 eol_short,
    output logic                 frame_done
);

    typedef enum logic {
        WAIT_SOF = 1'b0,
        ACTIVE   = 1'b1
    } state_t;

    // flast marks a tlast beat that belongs to the last window line; it is
    // what turns the final master handshake into a frame_done pulse.
    typedef struct packed {
        logic                  flast;
        logic                  user;
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } beat_t;

    localparam logic [CNT_WIDTH-1:0] ONE_C = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH:0]   ONE_E = {{CNT_WIDTH{1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic [CNT_WIDTH-1:0] sh_x_q, sh_x_d, sh_y_q, sh_y_d;
    logic [CNT_WIDTH-1:0] sh_w_q, sh_w_d, sh_h_q, sh_h_d;
    logic                 kept_any_q, kept_any_d;
    logic                 done_q, done_d;
    beat_t                main_q, main_d, skid_q, skid_d;
    logic                 m_valid_q, m_valid_d;
    logic                 skid_valid_q, skid_valid_d;
    logic                 s_tready_q, s_tready_d;
    logic                 sof_early_q, sof_early_d;
    logic                 eol_short_q, eol_short_d;
    logic                 frame_done_q, frame_done_d;

    // Evaluation-side combinational signals
    logic                 accept, is_sof, evaluating, keep;
    logic [CNT_WIDTH-1:0] ev_x, ev_y;
    logic [CNT_WIDTH-1:0] cfg_x, cfg_y, cfg_w, cfg_h;
    logic [CNT_WIDTH:0]   xe, ye;
    logic                 in_x, in_y, out_user, out_last, last_line;
    logic                 early_end, main_free;
    beat_t                new_beat;

    always_comb begin
        accept = s_axis_video.tvalid & s_tready_q;
        is_sof = accept & s_axis_video.tuser;

        // An SOF beat is evaluated at (0,0) against the live config, which is
        // latched into the shadow registers in the same cycle.
        ev_x  = is_sof ? '0     : x_q;
        ev_y  = is_sof ? '0     : y_q;
        cfg_x = is_sof ? crop_x : sh_x_q;
        cfg_y = is_sof ? crop_y : sh_y_q;
        cfg_w = is_sof ? crop_w : sh_w_q;
        cfg_h = is_sof ? crop_h : sh_h_q;

        // Window end computed one bit wider so x+w never wraps.
        xe = {1'b0, cfg_x} + {1'b0, cfg_w};
        ye = {1'b0, cfg_y} + {1'b0, cfg_h};

        evaluating = accept & ((state_q == ACTIVE) | is_sof);
        in_x = ({1'b0, ev_x} >= {1'b0, cfg_x}) & ({1'b0, ev_x} < xe);
        in_y = ({1'b0, ev_y} >= {1'b0, cfg_y}) & ({1'b0, ev_y} < ye);
        keep = evaluating & in_x & in_y;

        out_user  = is_sof | ~kept_any_q;
        out_last  = (({1'b0, ev_x} + ONE_E) == xe) | s_axis_video.tlast;
        last_line = ({1'b0, ev_y} + ONE_E) == ye;

        new_beat.data  = s_axis_video.tdata;
        new_beat.user  = out_user;
        new_beat.last  = out_last;
        new_beat.flast = out_last & last_line;

        sof_early_d = is_sof & (state_q == ACTIVE) & ((x_q != '0) | (y_q != '0));
        eol_short_d = evaluating & s_axis_video.tlast & in_y &
                      (({1'b0, ev_x} + ONE_E) < xe);

        // A restart that abandons a cropped frame which already produced
        // beats but never reached its final line still closes that frame.
        early_end = sof_early_d & kept_any_q & ~done_q;
    end

    // Position tracking FSM and config shadow
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        sh_x_d     = sh_x_q;
        sh_y_d     = sh_y_q;
        sh_w_d     = sh_w_q;
        sh_h_d     = sh_h_q;
        kept_any_d = kept_any_q;
        done_d     = done_q;

        if (is_sof) begin
            state_d    = ACTIVE;
            sh_x_d     = crop_x;
            sh_y_d     = crop_y;
            sh_w_d     = crop_w;
            sh_h_d     = crop_h;
            kept_any_d = keep;
            done_d     = keep & new_beat.flast;
        end else if (keep) begin
            kept_any_d = 1'b1;
            if (new_beat.flast) begin
                done_d = 1'b1;
            end
        end

        if (evaluating) begin
            if (s_axis_video.tlast) begin
                x_d = '0;
                y_d = ev_y + ONE_C;
            end else begin
                x_d = ev_x + ONE_C;
                y_d = ev_y;
            end
        end
    end

    // Output register plus skid. Only kept beats enter the pipeline.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        m_valid_d    = m_valid_q;
        skid_valid_d = skid_valid_q;
        main_free    = ~m_valid_q | m_axis_video.tready;

        if (skid_valid_q) begin
            // s_tready is low while the skid holds a beat, so no new beat
            // can arrive here; the skid simply drains first.
            if (main_free) begin
                main_d       = skid_q;
                m_valid_d    = 1'b1;
                skid_valid_d = 1'b0;
            end
        end else if (keep) begin
            if (main_free) begin
                main_d    = new_beat;
                m_valid_d = 1'b1;
            end else begin
                skid_d       = new_beat;
                skid_valid_d = 1'b1;
            end
        end else if (m_axis_video.tready) begin
            m_valid_d = 1'b0;
        end

        s_tready_d   = ~skid_valid_d;
        frame_done_d = (m_valid_q & m_axis_video.tready & main_q.last & main_q.flast) |
                       early_end;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= WAIT_SOF;
            x_q          <= '0;
            y_q          <= '0;
            sh_x_q       <= '0;
            sh_y_q       <= '0;
            sh_w_q       <= '0;
            sh_h_q       <= '0;
            kept_any_q   <= 1'b0;
            done_q       <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
            m_valid_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            s_tready_q   <= 1'b0;
            sof_early_q  <= 1'b0;
            eol_short_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            sh_x_q       <= sh_x_d;
            sh_y_q       <= sh_y_d;
            sh_w_q       <= sh_w_d;
            sh_h_q       <= sh_h_d;
            kept_any_q   <= kept_any_d;
            done_q       <= done_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
            m_valid_q    <= m_valid_d;
            skid_valid_q <= skid_valid_d;
            s_tready_q   <= s_tready_d;
            sof_early_q  <= sof_early_d;
            eol_short_q  <= eol_short_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign s_axis_video.tready = s_tready_q;
    assign m_axis_video.tvalid = m_valid_q;
    assign m_axis_video.tdata  = main_q.data;
    assign m_axis_video.tuser  = main_q.user;
    assign m_axis_video.tlast  = main_q.last;
    assign sof_early           = sof_early_q;
    assign eol_short           = eol_short_q;
    assign frame_done          = frame_done_q;

endmodule

// File: tb/tb_axis_video_crop.sv
module tb_axis_video_crop;
  localparam int DW = 16;
  localparam int CW = 12;

  // ---------------- clock / reset ----------------
  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [CW-1:0] crop_x = '0;
  logic [CW-1:0] crop_y = '0;
  logic [CW-1:0] crop_w = '0;
  logic [CW-1:0] crop_h = '0;
  logic          sof_early, eol_short, frame_done;

  axis_video_if #(.DATA_WIDTH(DW)) s_if ();
  axis_video_if #(.DATA_WIDTH(DW)) m_if ();

  axis_video_crop #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .crop_x       (crop_x),
    .crop_y       (crop_y),
    .crop_w       (crop_w),
    .crop_h       (crop_h),
    .s_axis_video (s_if),
    .m_axis_video (m_if),
    .sof_early    (sof_early),
    .eol_short    (eol_short),
    .frame_done   (frame_done)
  );

  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- output ready driver ----------------
  logic rnd_mode = 1'b0;
  logic ready_fix = 1'b1;

  always @(posedge aclk) begin
    #2;
    m_if.tready = rnd_mode ? 1'($urandom_range(0, 1)) : ready_fix;
  end

  // ---------------- scoreboard / monitor ----------------
  // expected word = {tuser, tlast, tdata}; tdata = {line[7:0], pixel[7:0]}
  logic [DW+1:0] exp_q[$];
  int            out_cnt = 0;
  int            extra_cnt = 0;
  int            sof_cnt = 0;
  int            eol_cnt = 0;
  int            fd_cnt = 0;
  logic          prev_stall = 1'b0;
  logic [DW+1:0] prev_word = '0;

  always @(negedge aclk) begin
    logic [DW+1:0] obs;
    logic [DW+1:0] w;
    obs = {m_if.tuser, m_if.tlast, m_if.tdata};
    if (!aresetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(m_if.tvalid), 32'd1);
        chk("stall_word", 32'(obs), 32'(prev_word));
      end
      if (m_if.tvalid && m_if.tready) begin
        out_cnt++;
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          chk("beat", 32'(obs), 32'(w));
        end else begin
          extra_cnt++;
        end
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_word  = obs;
      if (sof_early)  sof_cnt++;
      if (eol_short)  eol_cnt++;
      if (frame_done) fd_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  int b_out, b_sof, b_eol, b_fd;

  task automatic snap();
    b_out = out_cnt;
    b_sof = sof_cnt;
    b_eol = eol_cnt;
    b_fd  = fd_cnt;
  endtask

  task automatic exp_push(input int x, input int y, input logic u, input logic l);
    exp_q.push_back({u, l, 8'(y), 8'(x)});
  endtask

  task automatic do_reset();
    s_if.tvalid = 1'b0;
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk);
    #1;
  endtask

  task automatic send_beat(input int x, input int y, input logic u, input logic l);
    logic rdy;
    int   n;
    s_if.tdata  = {8'(y), 8'(x)};
    s_if.tuser  = u;
    s_if.tlast  = l;
    s_if.tvalid = 1'b1;
    n = 0;
    forever begin
      @(negedge aclk);
      rdy = s_if.tready;
      @(posedge aclk);
      #1;
      if (rdy) break;
      n++;
      if (n > 200) begin
        chk("s_tready_timeout", 32'(rdy), 32'd1);
        break;
      end
    end
    s_if.tvalid = 1'b0;
  endtask

  task automatic send_frame(input int w, input int h, input logic gaps);
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        if (gaps && ($urandom_range(0, 3) == 0)) begin
          @(posedge aclk);
          #1;
        end
        send_beat(x, y, (x == 0) && (y == 0), x == w - 1);
      end
    end
  endtask

  task automatic end_test(input string name, input int n_out, input int n_sof,
                          input int n_eol, input int n_fd);
    for (int i = 0; i < 400 && (exp_q.size() != 0 || m_if.tvalid); i++) @(posedge aclk);
    repeat (3) @(posedge aclk);
    #1;
    chk({name, "_left"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_nout"}, 32'(out_cnt - b_out), 32'(n_out));
    chk({name, "_sof_early"}, 32'(sof_cnt - b_sof), 32'(n_sof));
    chk({name, "_eol_short"}, 32'(eol_cnt - b_eol), 32'(n_eol));
    chk({name, "_frame_done"}, 32'(fd_cnt - b_fd), 32'(n_fd));
    exp_q.delete();
  endtask

  task automatic push_basic();
    exp_push(2, 1, 1'b1, 1'b0);
    exp_push(3, 1, 1'b0, 1'b0);
    exp_push(4, 1, 1'b0, 1'b1);
    exp_push(2, 2, 1'b0, 1'b0);
    exp_push(3, 2, 1'b0, 1'b0);
    exp_push(4, 2, 1'b0, 1'b1);
  endtask

  // ---------------- tests ----------------
  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tuser  = 1'b0;
    s_if.tlast  = 1'b0;

    // reset state
    @(negedge aclk);
    chk("rst_s_tready", 32'(s_if.tready), 32'd0);
    chk("rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
    chk("rst_m_tuser", 32'(m_if.tuser), 32'd0);
    chk("rst_m_tlast", 32'(m_if.tlast), 32'd0);
    chk("rst_pulses", 32'({sof_early, eol_short, frame_done}), 32'd0);
    @(posedge aclk);
    #1 aresetn = 1'b1;
    chk("rel_s_tready_0", 32'(s_if.tready), 32'd0);
    @(posedge aclk);
    #1;
    chk("rel_s_tready_1", 32'(s_if.tready), 32'd1);

    // 8x4 frame, window (2,1) 3x2, output always ready
    crop_x = 12'd2; crop_y = 12'd1; crop_w = 12'd3; crop_h = 12'd2;
    ready_fix = 1'b1;
    snap();
    push_basic();
    send_frame(8, 4, 1'b0);
    end_test("basic", 6, 0, 0, 1);

    // same stream, random backpressure and input gaps
    do_reset();
    snap();
    push_basic();
    rnd_mode = 1'b1;
    send_frame(8, 4, 1'b1);
    end_test("bp", 6, 0, 0, 1);
    rnd_mode = 1'b0;

    // window extends past 6-pixel lines
    do_reset();
    crop_x = 12'd4; crop_y = 12'd0; crop_w = 12'd4; crop_h = 12'd2;
    snap();
    exp_push(4, 0, 1'b1, 1'b0);
    exp_push(5, 0, 1'b0, 1'b1);
    exp_push(4, 1, 1'b0, 1'b0);
    exp_push(5, 1, 1'b0, 1'b1);
    send_frame(6, 3, 1'b0);
    end_test("short", 4, 0, 2, 1);

    // SOF injected at (3,2): old frame cut short, new frame restarts there
    do_reset();
    crop_x = 12'd2; crop_y = 12'd1; crop_w = 12'd3; crop_h = 12'd2;
    snap();
    exp_push(2, 1, 1'b1, 1'b0);
    exp_push(3, 1, 1'b0, 1'b0);
    exp_push(4, 1, 1'b0, 1'b1);
    exp_push(2, 2, 1'b0, 1'b0);
    push_basic();
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 8; x++)
        send_beat(x, y, (x == 0) && (y == 0), x == 7);
    for (int x = 0; x < 3; x++) send_beat(x, 2, 1'b0, 1'b0);
    send_frame(8, 4, 1'b0);
    end_test("sof_mid", 10, 1, 0, 2);

    // junk before first SOF, then a zero-width window
    do_reset();
    snap();
    for (int i = 0; i < 5; i++) send_beat(i, 0, 1'b0, i == 2);
    crop_w = 12'd0;
    send_frame(8, 4, 1'b0);
    end_test("junk_w0", 0, 0, 0, 0);

    // reset mid-line while stalled
    do_reset();
    crop_x = 12'd2; crop_y = 12'd1; crop_w = 12'd3; crop_h = 12'd2;
    ready_fix = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    snap();
    for (int x = 0; x < 8; x++) send_beat(x, 0, x == 0, x == 7);
    for (int x = 0; x < 4; x++) send_beat(x, 1, 1'b0, 1'b0);
    @(negedge aclk);
    chk("stalled_m_tvalid", 32'(m_if.tvalid), 32'd1);
    chk("stalled_s_tready", 32'(s_if.tready), 32'd0);
    chk("stalled_nout", 32'(out_cnt - b_out), 32'd0);
    #2 aresetn = 1'b0;
    #1;
    chk("arst_m_tvalid", 32'(m_if.tvalid), 32'd0);
    chk("arst_s_tready", 32'(s_if.tready), 32'd0);
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    ready_fix = 1'b1;
    chk("arel_s_tready_0", 32'(s_if.tready), 32'd0);
    @(posedge aclk);
    #1;
    chk("arel_s_tready_1", 32'(s_if.tready), 32'd1);
    chk("arel_m_tvalid", 32'(m_if.tvalid), 32'd0);
    snap();
    push_basic();
    send_frame(8, 4, 1'b0);
    end_test("after_rst", 6, 0, 0, 1);

    chk("extra_beats", 32'(extra_cnt), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
